// File: rtl/nco_sweep_ctrl.sv
// Linear FTW sweep (chirp) sequencer feeding the NCO phase accumulator.
// Optional descending leg enabled by defining SWEEP_PINGPONG_EN.
module nco_sweep_ctrl #(
    parameter int FTW_W   = 16,
    parameter int DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic [FTW_W-1:0] ftw,
    output logic             ftw_load,
    output logic             phase_clr,
    output logic             busy,
    output logic             done,
    output logic             dir
);

    // state | meaning
    // IDLE  | not sweeping, config writable, GO accepted
    // DWELL | holding an intermediate ftw for dwell+1 cycles
    // FINAL | holding the end-point ftw (stop, start, or degenerate start)
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_FINAL} state_t;

    localparam logic [DWELL_W-1:0] CNT_ONE = 1;

    state_t             state_q, state_d;
    logic [FTW_W-1:0]   start_q, start_d, stop_q, stop_d, step_q, step_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic               cont_q, cont_d;
    logic               ftw_load_q, ftw_load_d, phase_clr_q, phase_clr_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               ctrl_wr, go, abort, degenerate, up_clamp, cnt_zero;
    logic               do_launch, do_up, do_idle;
    logic [FTW_W:0]     sum;

`ifdef SWEEP_PINGPONG_EN
    logic               pingpong_q, pingpong_d, dir_q, dir_d, do_down, down_clamp;
    logic [FTW_W:0]     diff;

    // a borrow out of the subtraction counts as reaching start
    assign diff       = {1'b0, ftw_q} - {1'b0, step_q};
    assign down_clamp = diff[FTW_W] || (diff[FTW_W-1:0] <= start_q);
`endif

    assign ctrl_wr    = wr_en && (wr_addr == 3'd7);
    assign go         = ctrl_wr && wr_data[0];
    assign abort      = ctrl_wr && wr_data[2];
    assign degenerate = (step_q == '0) || (start_q >= stop_q);
    assign sum        = {1'b0, ftw_q} + {1'b0, step_q};
    assign up_clamp   = sum >= {1'b0, stop_q};
    assign cnt_zero   = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        ftw_d       = ftw_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ftw_load_d  = 1'b0;
        phase_clr_d = 1'b0;
        done_d      = 1'b0;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        do_launch   = 1'b0;
        do_up       = 1'b0;
        do_idle     = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        pingpong_d  = pingpong_q;
        dir_d       = dir_q;
        do_down     = 1'b0;
`endif

        if (wr_en && (state_q == S_IDLE)) begin
            case (wr_addr)
                3'd0: start_d[7:0]       = wr_data;
                3'd1: start_d[FTW_W-1:8] = wr_data[FTW_W-9:0];
                3'd2: stop_d[7:0]        = wr_data;
                3'd3: stop_d[FTW_W-1:8]  = wr_data[FTW_W-9:0];
                3'd4: step_d[7:0]        = wr_data;
                3'd5: step_d[FTW_W-1:8]  = wr_data[FTW_W-9:0];
                3'd6: dwell_d            = wr_data[DWELL_W-1:0];
                3'd7: begin
                    cont_d = wr_data[1];
`ifdef SWEEP_PINGPONG_EN
                    pingpong_d = wr_data[3];
`endif
                end
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (go && !abort)
                    do_launch = 1'b1;
            end
            S_DWELL: begin
                if (abort) begin
                    do_idle = 1'b1;
                end else if (cnt_zero) begin
                    do_up = 1'b1;
`ifdef SWEEP_PINGPONG_EN
                    if (dir_q) begin
                        do_up   = 1'b0;
                        do_down = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FINAL: begin
                if (abort) begin
                    do_idle = 1'b1;
                end else if (cnt_zero) begin
                    if (cont_q) begin
                        do_launch = 1'b1;
                    end else begin
                        do_idle = 1'b1;
                        done_d  = 1'b1;
                    end
`ifdef SWEEP_PINGPONG_EN
                    // ping-pong: stop end turns around, start end re-ascends without phase clear
                    if (pingpong_q && !degenerate) begin
                        do_launch = 1'b0;
                        do_idle   = 1'b0;
                        done_d    = 1'b0;
                        if (!dir_q) begin
                            do_down = 1'b1;
                        end else if (cont_q) begin
                            do_up = 1'b1;
                        end else begin
                            do_idle = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: do_idle = 1'b1;
        endcase

        if (do_idle) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end
        if (do_launch) begin
            ftw_d       = start_q;
            ftw_load_d  = 1'b1;
            phase_clr_d = 1'b1;
            busy_d      = 1'b1;
            cnt_d       = dwell_q;
            state_d     = degenerate ? S_FINAL : S_DWELL;
        end
        if (do_up) begin
            ftw_load_d = 1'b1;
            cnt_d      = dwell_q;
            if (up_clamp) begin
                ftw_d   = stop_q;
                state_d = S_FINAL;
            end else begin
                ftw_d   = sum[FTW_W-1:0];
                state_d = S_DWELL;
            end
        end
`ifdef SWEEP_PINGPONG_EN
        if (do_down) begin
            ftw_load_d = 1'b1;
            cnt_d      = dwell_q;
            if (down_clamp) begin
                ftw_d   = start_q;
                state_d = S_FINAL;
            end else begin
                ftw_d   = diff[FTW_W-1:0];
                state_d = S_DWELL;
            end
        end
        if (do_idle || do_launch || do_up)
            dir_d = 1'b0;
        if (do_down)
            dir_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            ftw_q       <= '0;
            cnt_q       <= '0;
            ftw_load_q  <= 1'b0;
            phase_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            pingpong_q  <= 1'b0;
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
            ftw_q       <= ftw_d;
            cnt_q       <= cnt_d;
            ftw_load_q  <= ftw_load_d;
            phase_clr_q <= phase_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SWEEP_PINGPONG_EN
            pingpong_q  <= pingpong_d;
            dir_q       <= dir_d;
`endif
        end
    end

    assign ftw       = ftw_q;
    assign ftw_load  = ftw_load_q;
    assign phase_clr = phase_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef SWEEP_PINGPONG_EN
    assign dir       = dir_q;
`else
    assign dir       = 1'b0;
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: sweep-level reference model plus directed cases.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] ftw;
    logic        ftw_load, phase_clr, busy, done, dir;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.FTW_W(16), .DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ftw       (ftw),
        .ftw_load  (ftw_load),
        .phase_clr (phase_clr),
        .busy      (busy),
        .done      (done),
        .dir       (dir)
    );

    typedef struct packed {
        logic [15:0] ftw;
        logic        load;
        logic        pclr;
        logic        busy;
        logic        done;
        logic        dir;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] idle_ftw;
    bit          cur_busy;
    bit          chk_en;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          m_start, m_stop, m_step, m_dwell;
    bit          m_cont, m_pp;
    int          load_cnt, pclr_cnt, done_cnt, busy_cnt, dir_cnt;
    bit          saw_zero;

    task automatic chk(input string nm, input int act, input int req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic push_val(input int v, input bit pclr, input bit d);
        exp_t e;
        for (int i = 0; i <= m_dwell; i++) begin
            e.ftw  = v[15:0];
            e.load = (i == 0);
            e.pclr = pclr && (i == 0);
            e.busy = 1'b1;
            e.done = 1'b0;
            e.dir  = d;
            exp_q.push_back(e);
        end
    endtask

    // Builds the whole expected output trace of one sweep from the configuration.
    task automatic gen_trace();
        int   up[$];
        int   dn[$];
        int   v;
        int   periods;
        bit   degen;
        bit   pp;
        exp_t e;
        degen = (m_step == 0) || (m_start >= m_stop);
        pp    = m_pp && !degen;
        up.push_back(m_start);
        if (!degen) begin
            v = m_start;
            while (1) begin
                v = v + m_step;
                if (v >= m_stop) begin
                    up.push_back(m_stop);
                    break;
                end
                up.push_back(v);
            end
        end
        if (pp) begin
            v = m_stop;
            while (1) begin
                v = v - m_step;
                if (v <= m_start) begin
                    dn.push_back(m_start);
                    break;
                end
                dn.push_back(v);
            end
        end
        periods = m_cont ? 3 : 1;
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < up.size(); i++) begin
                if (!(pp && p > 0 && i == 0))
                    push_val(up[i], (i == 0) && (p == 0 || !pp), 1'b0);
            end
            for (int i = 0; i < dn.size(); i++)
                push_val(dn[i], 1'b0, 1'b1);
        end
        if (!m_cont) begin
            e      = exp_q[exp_q.size()-1];
            e.load = 1'b0;
            e.pclr = 1'b0;
            e.busy = 1'b0;
            e.done = 1'b1;
            e.dir  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        exp_t a;
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.ftw  = idle_ftw;
                e.load = 1'b0;
                e.pclr = 1'b0;
                e.busy = 1'b0;
                e.done = 1'b0;
                e.dir  = 1'b0;
            end
            a.ftw  = ftw;
            a.load = ftw_load;
            a.pclr = phase_clr;
            a.busy = busy;
            a.done = done;
            a.dir  = dir;
            n_assert++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t ftw=%h/%h load=%b/%b pclr=%b/%b busy=%b/%b done=%b/%b dir=%b/%b (actual/required)",
                         $time, a.ftw, e.ftw, a.load, e.load, a.pclr, e.pclr,
                         a.busy, e.busy, a.done, e.done, a.dir, e.dir);
            end
            idle_ftw = e.ftw;
            cur_busy = e.busy;
            if (ftw_load)            load_cnt++;
            if (phase_clr)           pclr_cnt++;
            if (done)                done_cnt++;
            if (busy)                busy_cnt++;
            if (dir)                 dir_cnt++;
            if (busy && ftw == 16'h0) saw_zero = 1'b1;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        if (!cur_busy) begin
            case (a)
                3'd0: m_start = (m_start & 32'hFF00) | int'(d);
                3'd1: m_start = (m_start & 32'h00FF) | (int'(d) << 8);
                3'd2: m_stop  = (m_stop  & 32'hFF00) | int'(d);
                3'd3: m_stop  = (m_stop  & 32'h00FF) | (int'(d) << 8);
                3'd4: m_step  = (m_step  & 32'hFF00) | int'(d);
                3'd5: m_step  = (m_step  & 32'h00FF) | (int'(d) << 8);
                3'd6: m_dwell = int'(d);
                default: begin
                    m_cont = d[1];
`ifdef SWEEP_PINGPONG_EN
                    m_pp = d[3];
`endif
                end
            endcase
        end
        if (a == 3'd7) begin
            if (d[2]) begin
                if (cur_busy) exp_q.delete();
            end else if (d[0] && !cur_busy) begin
                gen_trace();
            end
        end
        #1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    task automatic cfg(input int s, input int p, input int st, input int dw);
        wr(3'd0, s[7:0]);
        wr(3'd1, s[15:8]);
        wr(3'd2, p[7:0]);
        wr(3'd3, p[15:8]);
        wr(3'd4, st[7:0]);
        wr(3'd5, st[15:8]);
        wr(3'd6, dw[7:0]);
    endtask

    task automatic clr_cnt();
        load_cnt = 0;
        pclr_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
        dir_cnt  = 0;
        saw_zero = 1'b0;
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain_timeout remaining=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_start  = 0;
        m_stop   = 0;
        m_step   = 0;
        m_dwell  = 0;
        m_cont   = 1'b0;
        m_pp     = 1'b0;
        idle_ftw = '0;
        cur_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        chk_en  = 1'b0;
        model_reset();
        clr_cnt();
        #12;
        chk("reset_outputs", int'({ftw, ftw_load, phase_clr, busy, done, dir}), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        #1;

        // basic ascending sweep
        cfg(32'h0100, 32'h0400, 32'h0100, 2);
        clr_cnt();
        wr(3'd7, 8'h01);
        chk("basic_trace_len", exp_q.size(), 13);
        chk("basic_first_ftw", int'(exp_q[0].ftw), 32'h0100);
        chk("basic_first_pclr", int'(exp_q[0].pclr), 1);
        chk("basic_second_ftw", int'(exp_q[3].ftw), 32'h0200);
        chk("basic_last_ftw", int'(exp_q[9].ftw), 32'h0400);
        chk("basic_done_slot", int'(exp_q[12].done), 1);
        drain(40);
        chk("basic_loads", load_cnt, 4);
        chk("basic_pclr", pclr_cnt, 1);
        chk("basic_done", done_cnt, 1);
        chk("basic_busy_cycles", busy_cnt, 12);

        // carry-out clamp at top of range
        cfg(32'hFF00, 32'hFFFF, 32'h0080, 0);
        clr_cnt();
        wr(3'd7, 8'h01);
        chk("ovf_trace_len", exp_q.size(), 4);
        chk("ovf_clamp_ftw", int'(exp_q[2].ftw), 32'hFFFF);
        drain(20);
        chk("ovf_no_zero", int'(saw_zero), 0);
        chk("ovf_loads", load_cnt, 3);
        chk("ovf_final_ftw", int'(ftw), 32'hFFFF);

        // start above stop
        cfg(32'h0500, 32'h0300, 32'h0010, 4);
        clr_cnt();
        wr(3'd7, 8'h01);
        chk("degen_trace_len", exp_q.size(), 6);
        drain(20);
        chk("degen_loads", load_cnt, 1);
        chk("degen_done", done_cnt, 1);

        // abort, write lockout, GO while busy, GO+ABORT
        cfg(32'h0100, 32'h0400, 32'h0100, 2);
        clr_cnt();
        wr(3'd7, 8'h01);
        repeat (4) @(negedge clk);
        #1;
        wr(3'd7, 8'h01);
        wr(3'd0, 8'hAA);
        wr(3'd7, 8'h04);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_busy_low", int'(busy), 0);
        wr(3'd7, 8'h01);
        repeat (2) @(negedge clk);
        #1;
        chk("lockout_start", int'(ftw), 32'h0100);
        wr(3'd7, 8'h04);
        repeat (2) @(negedge clk);
        #1;
        clr_cnt();
        wr(3'd7, 8'h05);
        repeat (4) @(negedge clk);
        #1;
        chk("goabort_loads", load_cnt, 0);
        chk("goabort_busy", int'(busy), 0);

        // asynchronous reset mid-sweep, then all-zero config
        wr(3'd7, 8'h01);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", int'({ftw, ftw_load, phase_clr, busy, done, dir}), 0);
        chk_en = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        clr_cnt();
        wr(3'd7, 8'h01);
        chk("zero_trace_len", exp_q.size(), 2);
        drain(10);
        chk("zero_loads", load_cnt, 1);
        chk("zero_done", done_cnt, 1);

        // continuous restart with phase clear
        cfg(32'h0100, 32'h0400, 32'h0100, 2);
        clr_cnt();
        wr(3'd7, 8'h03);
        repeat (20) @(negedge clk);
        #1;
        chk("cont_pclr", pclr_cnt, 2);
        wr(3'd7, 8'h04);
        repeat (2) @(negedge clk);
        #1;
        chk("cont_no_done", done_cnt, 0);
        wr(3'd7, 8'h00);

        // PINGPONG request (descends only when the feature is built in)
        clr_cnt();
        wr(3'd7, 8'h09);
`ifdef SWEEP_PINGPONG_EN
        chk("pp_trace_len", exp_q.size(), 22);
`else
        chk("pp_trace_len", exp_q.size(), 13);
`endif
        drain(60);
`ifdef SWEEP_PINGPONG_EN
        chk("pp_dir_cycles", dir_cnt, 9);
        chk("pp_loads", load_cnt, 7);
`else
        chk("pp_dir_cycles", dir_cnt, 0);
        chk("pp_loads", load_cnt, 4);
`endif
        chk("pp_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
